// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with a 2-flop input synchronizer, mid-bit
//            sampling and break/framing-error handling. When the macro
//            UART_RX_PARITY_EN is defined, an even-parity bit is expected
//            between the data bits and the stop bit (8E1).
// Ports    : clk        - clock, rising edge
//            rst_       - asynchronous active-low reset
//            rx_serial  - asynchronous serial line, idle high, LSB first
//            rx_data    - last correctly framed byte (held until next one)
//            rx_valid   - one-cycle pulse, rx_data updated
//            frame_err  - one-cycle pulse, stop bit sampled low
//            parity_err - one-cycle pulse alongside rx_valid on parity
//                         mismatch (tied low without UART_RX_PARITY_EN)
//            rx_busy    - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int unsigned c_DIVISOR   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned c_HALF      = c_DIVISOR / 2;
  localparam logic [31:0] c_DIV_LAST  = 32'(c_DIVISOR - 1);
  localparam logic [31:0] c_HALF_LAST = 32'(c_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t      r_state,     w_state;
  logic [31:0] r_baud_cnt,  w_baud_cnt;
  logic [2:0]  r_bit_index, w_bit_index;
  logic [7:0]  r_shifter,   w_shifter;
  logic [7:0]  r_rx_data,   w_rx_data;
  logic        r_rx_valid,  w_rx_valid;
  logic        r_frame_err, w_frame_err;
  logic        r_sync_meta;
  logic        r_sync;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bad,    w_par_bad;
  logic        r_parity_err, w_parity_err;
`endif

  // Two-flop synchronizer; flops reset to the idle (high) line level so a
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
    end else begin
      r_sync_meta <= rx_serial;
      r_sync      <= r_sync_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_index  <= '0;
      r_shifter    <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_baud_cnt   <= w_baud_cnt;
      r_bit_index  <= w_bit_index;
      r_shifter    <= w_shifter;
      r_rx_data    <= w_rx_data;
      r_rx_valid   <= w_rx_valid;
      r_frame_err  <= w_frame_err;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= w_par_bad;
      r_parity_err <= w_parity_err;
`endif
    end
  end

  always_comb begin
    w_state      = r_state;
    w_baud_cnt   = r_baud_cnt;
    w_bit_index  = r_bit_index;
    w_shifter    = r_shifter;
    w_rx_data    = r_rx_data;
    w_rx_valid   = 1'b0;
    w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad    = r_par_bad;
    w_parity_err = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_cnt = '0;
        if (!r_sync) w_state = S_START;
      end
      // Re-check the line half a bit in; a short low pulse is a glitch.
      S_START: begin
        if (r_baud_cnt == c_HALF_LAST) begin
          w_baud_cnt = '0;
          if (!r_sync) begin
            w_state     = S_DATA;
            w_bit_index = '0;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_baud_cnt = r_baud_cnt + 32'd1;
        end
      end
      // Counter is now phase-aligned to bit centres; LSB arrives first, so
      // shift in from the top.
      S_DATA: begin
        if (r_baud_cnt == c_DIV_LAST) begin
          w_baud_cnt = '0;
          w_shifter  = {r_sync, r_shifter[7:1]};
          if (r_bit_index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state = S_PARITY;
`else
            w_state = S_STOP;
`endif
          end else begin
            w_bit_index = r_bit_index + 3'd1;
          end
        end else begin
          w_baud_cnt = r_baud_cnt + 32'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: data bits plus parity bit must hold an even count of 1s.
      S_PARITY: begin
        if (r_baud_cnt == c_DIV_LAST) begin
          w_baud_cnt = '0;
          w_par_bad  = ^{r_shifter, r_sync};
          w_state    = S_STOP;
        end else begin
          w_baud_cnt = r_baud_cnt + 32'd1;
        end
      end
`endif
      S_STOP: begin
        if (r_baud_cnt == c_DIV_LAST) begin
          w_baud_cnt = '0;
          if (r_sync) begin
            w_rx_data    = r_shifter;
            w_rx_valid   = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_parity_err = r_par_bad;
`endif
            w_state      = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state     = S_WAIT_HIGH;
          end
        end else begin
          w_baud_cnt = r_baud_cnt + 32'd1;
        end
      end
      // A low line here is a break or bad frame tail; waiting for high keeps
      // it from being reparsed as a stream of 0x00 frames.
      S_WAIT_HIGH: begin
        w_baud_cnt = '0;
        if (r_sync) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at 10 clocks per bit. Frames are
//            built bit by bit from the byte value; expected pulse counts and
//            held data come from a frame-level model of what each frame
//            should produce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk;
  logic       rst_;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  // Frame-level model state
  int         exp_valid = 0;
  int         exp_ferr  = 0;
  int         exp_perr  = 0;
  logic [7:0] exp_data  = 8'h00;

  // Observed pulse statistics
  int         n_valid   = 0;
  int         n_ferr    = 0;
  int         n_perr    = 0;
  int         n_both    = 0;
  int         n_lone_pe = 0;

  uart_rx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .rx_serial  (rx_serial),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)               n_valid   <= n_valid + 1;
    if (frame_err)              n_ferr    <= n_ferr + 1;
    if (parity_err)             n_perr    <= n_perr + 1;
    if (rx_valid && frame_err)  n_both    <= n_both + 1;
    if (parity_err && !rx_valid) n_lone_pe <= n_lone_pe + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_valid_cnt"}, n_valid,  exp_valid);
    check({tag, "_ferr_cnt"},  n_ferr,   exp_ferr);
    check({tag, "_perr_cnt"},  n_perr,   exp_perr);
    check({tag, "_rx_data"},   rx_data,  exp_data);
    check({tag, "_busy_idle"}, rx_busy,  1'b0);
  endtask

  // Sends one frame (start, 8 data LSB first, optional parity, stop), leaves
  // the line high, updates the model and checks the outcome.
  task automatic send_frame(input string tag, input logic [7:0] d,
                            input logic stop_b, input logic par_b);
    rx_serial = 1'b0;
    tick(10);
    check({tag, "_busy_mid"}, rx_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      tick(10);
    end
`ifdef UART_RX_PARITY_EN
    rx_serial = par_b;
    tick(10);
`endif
    rx_serial = stop_b;
    tick(10);
    rx_serial = 1'b1;
    if (stop_b) begin
      exp_valid++;
      exp_data = d;
`ifdef UART_RX_PARITY_EN
      if (par_b != ^d) exp_perr++;
`endif
    end else begin
      exp_ferr++;
    end
    tick(6);
    check_totals(tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    logic       rp;
    int         gap;
    logic       released;

    rst_      = 1'b0;
    rx_serial = 1'b1;
    tick(3);
    check("reset_rx_data",    rx_data,    8'h00);
    check("reset_rx_valid",   rx_valid,   1'b0);
    check("reset_frame_err",  frame_err,  1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_rx_busy",    rx_busy,    1'b0);
    rst_ = 1'b1;
    tick(5);

    // Basic good frame
    send_frame("a5", 8'hA5, 1'b1, ^8'hA5);

    // Short low glitch: START entered, then rejected
    rx_serial = 1'b0;
    tick(3);
    check("glitch_busy_high", rx_busy, 1'b1);
    rx_serial = 1'b1;
    released = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (!rx_busy) begin
        released = 1'b1;
        break;
      end
    end
    check("glitch_busy_release", released, 1'b1);
    tick(4);
    check_totals("glitch");

    // Bad stop bit, previous data held, then recovery
    send_frame("3c_badstop", 8'h3C, 1'b0, ^8'h3C);
    send_frame("5a", 8'h5A, 1'b1, ^8'h5A);

    // Break: line low for 200 clocks gives exactly one frame error
    rx_serial = 1'b0;
    tick(200);
    rx_serial = 1'b1;
    exp_ferr++;
    tick(6);
    check_totals("break");
    send_frame("ff_after_break", 8'hFF, 1'b1, ^8'hFF);

    // Reset during bit 4 of 0x81
    rd = 8'h81;
    rx_serial = 1'b0;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      rx_serial = rd[i];
      tick(10);
    end
    rx_serial = rd[4];
    tick(5);
    rst_ = 1'b0;
    #1;
    check("midrst_rx_data",    rx_data,    8'h00);
    check("midrst_rx_valid",   rx_valid,   1'b0);
    check("midrst_frame_err",  frame_err,  1'b0);
    check("midrst_parity_err", parity_err, 1'b0);
    check("midrst_rx_busy",    rx_busy,    1'b0);
    exp_data = 8'h00;
    rx_serial = 1'b1;
    tick(3);
    rst_ = 1'b1;
    tick(120);
    check_totals("after_rst");
    send_frame("81_after_rst", 8'h81, 1'b1, ^8'h81);

`ifdef UART_RX_PARITY_EN
    send_frame("07_par0", 8'h07, 1'b1, 1'b0);
    send_frame("07_par1", 8'h07, 1'b1, 1'b1);
`endif

    // Randomized frames with occasional bad stop / wrong parity and gaps,
    // including back-to-back frames.
    for (int k = 0; k < 12; k++) begin
      rd  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 4) != 0);
      rp  = ($urandom_range(0, 2) == 0) ? ~(^rd) : ^rd;
      gap = $urandom_range(0, 12);
      send_frame($sformatf("rand%0d", k), rd, rs, rp);
      if (gap > 0) tick(gap);
    end

    check("valid_and_ferr_overlap", n_both,    0);
    check("parity_err_without_valid", n_lone_pe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate; DIVISOR = CLK_FREQ/BAUD_RATE (integer), HALF = DIVISOR/2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 rx_serial  input  1  asynchronous serial line, idle high, 8N1 frames sent LSB first.
REQ-006 rx_data  output  8  last correctly framed byte; holds value until the next good frame.
REQ-007 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-008 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 parity_err  output  1  one-cycle pulse coincident with rx_valid when parity mismatches; see Configuration.
REQ-010 rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 rx_serial SHALL pass through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only; synchronizer latency 2 cycles.
REQ-012 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH; 32-bit baud_cnt, 3-bit bit_index, 8-bit shifter.
REQ-013 IDLE: baud_cnt=0; rx_sync==0 -> START.
REQ-014 START: baud_cnt increments; at baud_cnt==HALF-1: rx_sync==0 -> DATA, baud_cnt=0, bit_index=0; rx_sync==1 -> IDLE (glitch rejected, no pulse).
REQ-015 DATA: at baud_cnt==DIVISOR-1 sample rx_sync into shifter MSB, shift right, baud_cnt=0; after bit_index==7 -> PARITY if enabled, else STOP; otherwise bit_index+1.
REQ-016 STOP: at baud_cnt==DIVISOR-1 sample rx_sync; 1 -> rx_data<=shifter, rx_valid=1, -> IDLE; 0 -> frame_err=1, rx_data unchanged, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_sync==1, then -> IDLE; a held-low line (break) SHALL produce exactly one frame_err and no spurious frames.
REQ-018 rx_valid, frame_err, parity_err SHALL be registered, high for exactly one cycle following the stop-sample edge, otherwise 0; rx_valid and frame_err never both high.
REQ-019 A falling edge arriving in the same cycle the FSM returns to IDLE SHALL be detected on the next cycle (at most one cycle start slip).
REQ-020 No backpressure; a new frame overwrites rx_data regardless of consumer.

Reset
REQ-021 rst_ low SHALL immediately force: state IDLE, synchronizer flops 1, baud_cnt 0, bit_index 0, shifter 0, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, rx_busy 0.
REQ-022 Reset mid-frame SHALL discard the partial frame with no output pulse; reception resumes on the next falling edge after release.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: PARITY state inserted after DATA; at baud_cnt==DIVISOR-1 sample even-parity bit; mismatch recorded and reported as parity_err alongside rx_valid after a good stop bit; data still delivered.
REQ-024 Macro UART_RX_PARITY_EN undefined: no PARITY state, frames are 8N1, parity_err tied 0.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, DIVISOR=10, HALF=5)
REQ-025 Send 0xA5 8N1 at 10 clk/bit -> one rx_valid pulse, rx_data=0xA5, frame_err=0, rx_busy low after pulse.
REQ-026 Drive rx_serial low for 3 clk then high -> no state beyond START, no pulses, rx_busy returns 0 within 8 clk.
REQ-027 Send 0x3C with stop bit 0, line then high -> frame_err pulse once, rx_data holds previous 0xA5, next frame 0x5A received correctly.
REQ-028 Hold rx_serial low 200 clk (break) -> exactly one frame_err, zero rx_valid; after release, 0xFF frame received.
REQ-029 Assert rst_ during bit 4 of 0x81 -> all outputs 0 immediately, no rx_valid; subsequent 0x81 received correctly.
REQ-030 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> rx_valid and parity_err both pulse, rx_data=0x07; with parity 1 -> parity_err stays 0.
